// File: rtl/sync_fifo_pkg.sv
// Shared types, defaults and elaboration helpers for the sync_fifo_param family.
package sync_fifo_pkg;

    // Combinational status flags, grouped so they travel together.
    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
    } fifo_status_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    // True when v is a power of two and at least 2.
    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_param: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module sync_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the incoming word on an accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO with power-of-2 depth, programmable almost-full/almost-empty
// thresholds, exact occupancy and standard (FWFT=0) or first-word-fall-through
// (FWFT=1) read mode.
// Optional build macro SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
// flags with an err_clr input.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     almost_full,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   level
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    input  logic                     err_clr,
    output logic                     overflow,
    output logic                     underflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_THR = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_THR = AE_LEVEL[AW:0];

    // Reject configurations the pointer arithmetic cannot represent.
    generate
        if (!is_pow2(DEPTH) || AF_LEVEL < 0 || AF_LEVEL > DEPTH ||
            AE_LEVEL < 0 || AE_LEVEL >= DEPTH || WIDTH < 1) begin : g_bad_cfg
            $error("sync_fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL/WIDTH");
        end
    endgenerate

    // Handshake: wr_en is a request that is accepted on a rising edge only when
    // full is low (full acts as an inverted ready); rd_en is accepted only when
    // empty is low. A request seen against the opposing flag is dropped without
    // any state change, and both sides are judged on the flags at cycle start.
    logic [AW:0]      wptr, rptr;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] mem_rdata;
    fifo_status_t     status;

    assign wr_acc = wr_en && !status.full;
    assign rd_acc = rd_en && !status.empty;

    // Advance the write/read pointers on accepted operations.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
        end
    end

    // Occupancy and flags derived purely from the registered pointers.
    always_comb begin
        level               = wptr - rptr;
        status.empty        = (wptr == rptr);
        status.full         = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
        status.almost_full  = (level >= AF_THR);
        status.almost_empty = (level <= AE_THR);
    end

    assign full         = status.full;
    assign almost_full  = status.almost_full;
    assign empty        = status.empty;
    assign almost_empty = status.almost_empty;

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc && nrst),
        .waddr (wptr[AW-1:0]),
        .wdata (wr_data),
        .raddr (rptr[AW-1:0]),
        .rdata (mem_rdata)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue is presented directly; rd_en acknowledges it.
            assign rd_data  = mem_rdata;
            assign rd_valid = !status.empty;
        end else begin : g_std
            logic [WIDTH-1:0] rd_data_q;
            logic             rd_valid_q;

            // Register the head word on an accepted read; valid pulses one cycle.
            always_ff @(posedge clk) begin
                if (!nrst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem_rdata;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    // Sticky error flags; a new error wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && status.full)     overflow_q <= 1'b1;
            else if (err_clr)             overflow_q <= 1'b0;
            if (rd_en && status.empty)    underflow_q <= 1'b1;
            else if (err_clr)             underflow_q <= 1'b0;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param: a standard-read instance
// (dut0) driven from a vector table plus hand sequences, and an FWFT instance
// (dut1) for fall-through behaviour.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       nrst;
    logic       wr_en0, rd_en0, wr_en1, rd_en1;
    logic [7:0] wr_data0, wr_data1;
    logic [7:0] rd_data0, rd_data1;
    logic       rd_valid0, rd_valid1;
    logic       full0, af0, empty0, ae0;
    logic       full1, af1, empty1, ae1;
    logic [3:0] level0, level1;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic       err_clr0, err_clr1;
    logic       ovf0, unf0, ovf1, unf1;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) dut0 (
        .clk(clk), .nrst(nrst), .wr_en(wr_en0), .wr_data(wr_data0), .rd_en(rd_en0),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .almost_full(af0),
        .empty(empty0), .almost_empty(ae0), .level(level0)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .err_clr(err_clr0), .overflow(ovf0), .underflow(unf0)
`endif
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dut1 (
        .clk(clk), .nrst(nrst), .wr_en(wr_en1), .wr_data(wr_data1), .rd_en(rd_en1),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .almost_full(af1),
        .empty(empty1), .almost_empty(ae1), .level(level1)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .err_clr(err_clr1), .overflow(ovf1), .underflow(unf1)
`endif
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [3:0] lvl;
        logic       full;
        logic       af;
        logic       empty;
        logic       ae;
        logic       rv;
        logic [7:0] rdat;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [7:0] d);
        wr_en0 = 1'b1; wr_data0 = d; rd_en0 = 1'b0;
        tick();
        wr_en0 = 1'b0;
        exp_q.push_back(d);
        chk("push_level", 32'(level0), 32'(exp_q.size()));
    endtask

    task automatic pop0();
        logic [7:0] e;
        rd_en0 = 1'b1; wr_en0 = 1'b0;
        tick();
        rd_en0 = 1'b0;
        e = exp_q.pop_front();
        chk("pop_valid", 32'(rd_valid0), 32'd1);
        chk("pop_data", 32'(rd_data0), 32'(e));
        chk("pop_level", 32'(level0), 32'(exp_q.size()));
    endtask

    initial begin
        logic [7:0] d;

        vecs[0]  = '{1'b1, 1'b0, 8'h01, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 8'h02, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 8'h03, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, 8'h04, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 8'h05, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 1'b0, 8'h06, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, 1'b0, 8'h07, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 1'b0, 8'h08, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{1'b1, 1'b0, 8'hFF, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 1'b1, 8'h00, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01};
        vecs[10] = '{1'b0, 1'b1, 8'h00, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02};
        vecs[11] = '{1'b0, 1'b1, 8'h00, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03};
        vecs[12] = '{1'b0, 1'b1, 8'h00, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h04};
        vecs[13] = '{1'b0, 1'b1, 8'h00, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05};
        vecs[14] = '{1'b0, 1'b1, 8'h00, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h06};
        vecs[15] = '{1'b0, 1'b1, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h07};
        vecs[16] = '{1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h08};
        vecs[17] = '{1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h08};
        vecs[18] = '{1'b1, 1'b1, 8'h11, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h08};
        vecs[19] = '{1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11};

        // Reset: requests asserted during reset must be ignored.
        nrst = 1'b0;
        wr_en0 = 1'b1; rd_en0 = 1'b1; wr_data0 = 8'h5A;
        wr_en1 = 1'b1; rd_en1 = 1'b1; wr_data1 = 8'h5A;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        err_clr0 = 1'b0; err_clr1 = 1'b0;
`endif
        tick();
        tick();
        chk("rst_empty", 32'(empty0), 32'd1);
        chk("rst_ae", 32'(ae0), 32'd1);
        chk("rst_full", 32'(full0), 32'd0);
        chk("rst_af", 32'(af0), 32'd0);
        chk("rst_level", 32'(level0), 32'd0);
        chk("rst_rv", 32'(rd_valid0), 32'd0);
        chk("rst_rdata", 32'(rd_data0), 32'd0);
        chk("rst_fwft_rv", 32'(rd_valid1), 32'd0);
        chk("rst_fwft_level", 32'(level1), 32'd0);
        wr_en0 = 1'b0; rd_en0 = 1'b0; wr_en1 = 1'b0; rd_en1 = 1'b0;
        nrst = 1'b1;
        tick();

        // Vector table: fill, overfill, drain, underflow, simultaneous at empty.
        for (int i = 0; i < 20; i++) begin
            wr_en0 = vecs[i].wr; rd_en0 = vecs[i].rd; wr_data0 = vecs[i].din;
            tick();
            chk($sformatf("v%0d_level", i), 32'(level0), 32'(vecs[i].lvl));
            chk($sformatf("v%0d_full", i), 32'(full0), 32'(vecs[i].full));
            chk($sformatf("v%0d_af", i), 32'(af0), 32'(vecs[i].af));
            chk($sformatf("v%0d_empty", i), 32'(empty0), 32'(vecs[i].empty));
            chk($sformatf("v%0d_ae", i), 32'(ae0), 32'(vecs[i].ae));
            chk($sformatf("v%0d_rv", i), 32'(rd_valid0), 32'(vecs[i].rv));
            chk($sformatf("v%0d_rdata", i), 32'(rd_data0), 32'(vecs[i].rdat));
        end
        wr_en0 = 1'b0; rd_en0 = 1'b0;

        // Steady state at level 4 across the pointer wrap.
        d = 8'h20;
        for (int i = 0; i < 4; i++) begin
            push0(d);
            d++;
        end
        for (int i = 0; i < 20; i++) begin
            logic [7:0] e;
            wr_en0 = 1'b1; rd_en0 = 1'b1; wr_data0 = d;
            tick();
            exp_q.push_back(d);
            e = exp_q.pop_front();
            d++;
            chk("wrap_level", 32'(level0), 32'd4);
            chk("wrap_rv", 32'(rd_valid0), 32'd1);
            chk("wrap_data", 32'(rd_data0), 32'(e));
        end
        wr_en0 = 1'b0; rd_en0 = 1'b0;

        // Fill to full, then simultaneous write+read: write dropped, read taken.
        for (int i = 0; i < 4; i++) begin
            push0(d);
            d++;
        end
        chk("full_set", 32'(full0), 32'd1);
        wr_en0 = 1'b1; rd_en0 = 1'b1; wr_data0 = 8'hEE;
        tick();
        wr_en0 = 1'b0; rd_en0 = 1'b0;
        chk("full_simul_level", 32'(level0), 32'd7);
        chk("full_simul_full", 32'(full0), 32'd0);
        chk("full_simul_data", 32'(rd_data0), 32'(exp_q.pop_front()));
        while (exp_q.size() > 0) pop0();
        chk("drain_empty", 32'(empty0), 32'd1);

        // Mid-stream reset discards contents.
        push0(8'hC1);
        push0(8'hC2);
        pop0();
        nrst = 1'b0; wr_en0 = 1'b1; wr_data0 = 8'hC3;
        tick();
        nrst = 1'b1; wr_en0 = 1'b0;
        exp_q.delete();
        chk("midrst_level", 32'(level0), 32'd0);
        chk("midrst_empty", 32'(empty0), 32'd1);
        chk("midrst_rv", 32'(rd_valid0), 32'd0);
        chk("midrst_rdata", 32'(rd_data0), 32'd0);

        // FWFT: head word falls through without rd_en.
        wr_en1 = 1'b1; wr_data1 = 8'hA5;
        tick();
        wr_en1 = 1'b0;
        chk("fwft_rv", 32'(rd_valid1), 32'd1);
        chk("fwft_data", 32'(rd_data1), 32'hA5);
        tick();
        chk("fwft_hold", 32'(rd_data1), 32'hA5);
        wr_en1 = 1'b1; wr_data1 = 8'h3C;
        tick();
        wr_en1 = 1'b0;
        chk("fwft_level2", 32'(level1), 32'd2);
        chk("fwft_head", 32'(rd_data1), 32'hA5);
        rd_en1 = 1'b1;
        tick();
        chk("fwft_next", 32'(rd_data1), 32'h3C);
        chk("fwft_next_rv", 32'(rd_valid1), 32'd1);
        tick();
        rd_en1 = 1'b0;
        chk("fwft_empty", 32'(empty1), 32'd1);
        chk("fwft_rv_low", 32'(rd_valid1), 32'd0);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
        // Sticky error flags.
        rd_en0 = 1'b1;
        tick();
        rd_en0 = 1'b0;
        chk("unf_set", 32'(unf0), 32'd1);
        chk("ovf_clear", 32'(ovf0), 32'd0);
        for (int i = 0; i < 8; i++) push0(8'(i));
        wr_en0 = 1'b1; wr_data0 = 8'h99;
        tick();
        wr_en0 = 1'b0;
        chk("ovf_set", 32'(ovf0), 32'd1);
        tick();
        chk("ovf_held", 32'(ovf0), 32'd1);
        chk("unf_held", 32'(unf0), 32'd1);
        err_clr0 = 1'b1;
        tick();
        err_clr0 = 1'b0;
        chk("ovf_clr", 32'(ovf0), 32'd0);
        chk("unf_clr", 32'(unf0), 32'd0);
        wr_en0 = 1'b1; err_clr0 = 1'b1;
        tick();
        wr_en0 = 1'b0; err_clr0 = 1'b0;
        chk("ovf_set_beats_clr", 32'(ovf0), 32'd1);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        exp_q.delete();
        chk("err_rst_ovf", 32'(ovf0), 32'd0);
        chk("err_rst_level", 32'(level0), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
